// File: rtl/ledd_pkg.sv
// Shared geometry for the LED display controller: pixel word, SRAM address,
// line and frame sizes, plus derived counter widths.
package ledd_pkg;
    localparam int DW             = 16;
    localparam int AW             = 9;
    localparam int WORDS_PER_LINE = 16;
    localparam int LINES          = 32;
    localparam int FRAME_WORDS    = LINES * WORDS_PER_LINE;

    localparam int LINE_W = 6;
    localparam int BIT_W  = $clog2(DW);
    localparam int WPL_W  = $clog2(WORDS_PER_LINE);
endpackage

// File: rtl/serial_deser.sv
// Serial-to-parallel deserialiser: MSB-first bits qualified by den; word_vld is
// combinational on the edge that samples the last bit; no backpressure (den gaps just stall).
module serial_deser #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          den,
    input  logic          dai,
    output logic          word_vld,
    output logic [DW-1:0] word_dat
);
    localparam int BIT_W = $clog2(DW);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

    // Only DW-1 bits need storage: the final bit goes straight into word_dat.
    logic [DW-2:0]    sr_q, sr_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign word_vld = den && (bit_cnt_q == BIT_LAST);
    assign word_dat = {sr_q, dai};

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (den) begin
            sr_d      = {sr_q[DW-3:0], dai};
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/pixel_loader.sv
// Pixel loader: deserialised words written to frame SRAM port B one DCK after the 16th bit; no
// backpressure. LOADER_DOUBLE_BUFFER_EN adds a bank bit to AB and the rd_bank output.
module pixel_loader
    import ledd_pkg::*;
(
    input  logic              DCK,
    input  logic              rst,
    input  logic              DEN,
    input  logic              DAI,
    input  logic              frame_ack,
    output logic              CENB,
`ifdef LOADER_DOUBLE_BUFFER_EN
    output logic [AW:0]       AB,
    output logic              rd_bank,
`else
    output logic [AW-1:0]     AB,
`endif
    output logic [DW-1:0]     DB,
    output logic              line_done,
    output logic              frame_done,
    output logic              frame_ready,
    output logic [LINE_W-1:0] line_idx,
    output logic              err_overrun
);
`ifdef LOADER_DOUBLE_BUFFER_EN
    localparam int ABW = AW + 1;
`else
    localparam int ABW = AW;
`endif
    localparam logic [AW-1:0]     FRAME_LAST    = AW'(FRAME_WORDS - 1);
    localparam logic [WPL_W-1:0]  LINE_LAST     = WPL_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_IDX_LAST = LINE_W'(LINES - 1);

    logic          word_vld;
    logic [DW-1:0] word_dat;

    serial_deser #(.DW(DW)) u_deser (
        .clk      (DCK),
        .rst      (rst),
        .den      (DEN),
        .dai      (DAI),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    logic              cenb_q, cenb_d;
    logic [ABW-1:0]    ab_q, ab_d;
    logic [DW-1:0]     db_q, db_d;
    logic [AW-1:0]     word_cnt_q, word_cnt_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_ready_q, frame_ready_d;
    logic [LINE_W-1:0] line_idx_q, line_idx_d;
    logic              err_q, err_d;
`ifdef LOADER_DOUBLE_BUFFER_EN
    logic              bank_q, bank_d;
    logic              rd_bank_q, rd_bank_d;
`endif

    always_comb begin
        cenb_d        = 1'b1;
        ab_d          = ab_q;
        db_d          = db_q;
        word_cnt_d    = word_cnt_q;
        line_done_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_ready_d = frame_ready_q;
        line_idx_d    = line_idx_q;
        err_d         = err_q;
`ifdef LOADER_DOUBLE_BUFFER_EN
        bank_d        = bank_q;
        rd_bank_d     = rd_bank_q;
`endif

        if (word_vld) begin
            cenb_d       = 1'b0;
            db_d         = word_dat;
`ifdef LOADER_DOUBLE_BUFFER_EN
            ab_d         = {bank_q, word_cnt_q};
`else
            ab_d         = word_cnt_q;
`endif
            line_done_d  = (word_cnt_q[WPL_W-1:0] == LINE_LAST);
            frame_done_d = (word_cnt_q == FRAME_LAST);
            word_cnt_d   = frame_done_d ? '0 : word_cnt_q + 1'b1;
        end

        // line_idx moves in the cycle after the line's last write.
        if (line_done_q) begin
            line_idx_d = (line_idx_q == LINE_IDX_LAST) ? '0 : line_idx_q + 1'b1;
        end

        if (frame_ack) begin
            frame_ready_d = 1'b0;
        end
        if (frame_done_q) begin
            frame_ready_d = 1'b1;
        end

`ifdef LOADER_DOUBLE_BUFFER_EN
        // An unconsumed frame pins the display bank: keep writing into the same bank.
        if (frame_done_q) begin
            if (frame_ready_q) begin
                err_d = 1'b1;
            end else begin
                bank_d    = ~bank_q;
                rd_bank_d = bank_q;
            end
        end
`else
        if (!cenb_q && (ab_q == '0) && frame_ready_q) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            cenb_q        <= 1'b1;
            ab_q          <= '0;
            db_q          <= '0;
            word_cnt_q    <= '0;
            line_done_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            line_idx_q    <= '0;
            err_q         <= 1'b0;
`ifdef LOADER_DOUBLE_BUFFER_EN
            bank_q        <= 1'b0;
            rd_bank_q     <= 1'b0;
`endif
        end else begin
            cenb_q        <= cenb_d;
            ab_q          <= ab_d;
            db_q          <= db_d;
            word_cnt_q    <= word_cnt_d;
            line_done_q   <= line_done_d;
            frame_done_q  <= frame_done_d;
            frame_ready_q <= frame_ready_d;
            line_idx_q    <= line_idx_d;
            err_q         <= err_d;
`ifdef LOADER_DOUBLE_BUFFER_EN
            bank_q        <= bank_d;
            rd_bank_q     <= rd_bank_d;
`endif
        end
    end

    assign CENB        = cenb_q;
    assign AB          = ab_q;
    assign DB          = db_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign frame_ready = frame_ready_q;
    assign line_idx    = line_idx_q;
    assign err_overrun = err_q;
`ifdef LOADER_DOUBLE_BUFFER_EN
    assign rd_bank     = rd_bank_q;
`endif
endmodule
